// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O bus fabric: FSM states, status-page
// register offsets and sticky flag bit positions.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] STAT_FLAGS = 4'd0;
  localparam logic [3:0] STAT_ADDR  = 4'd1;
  localparam logic [3:0] STAT_TOCNT = 4'd2;

  localparam int unsigned FLAG_UNMAPPED = 0;
  localparam int unsigned FLAG_TIMEOUT  = 1;

endpackage

// File: rtl/io_bus_fabric_if.sv
// CPU port and peripheral slot bus of the I/O fabric.
// master: the fabric (serves the CPU, drives the slots); slave: CPU and peripherals.
interface io_bus_fabric_if #(
  parameter int unsigned N_SLOTS = 8
);
  logic [15:0]          cpu_addr;
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic [15:0]          cpu_dout;
  logic [15:0]          cpu_din;
  logic                 cpu_stall;

  logic [N_SLOTS-1:0]   slot_cs;
  logic [3:0]           slot_addr;
  logic                 slot_rd;
  logic                 slot_wr;
  logic [15:0]          slot_wdata;
  logic [16*N_SLOTS-1:0] slot_rdata;
  logic [N_SLOTS-1:0]   slot_ack;

  modport master (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    output cpu_din, cpu_stall,
    output slot_cs, slot_addr, slot_rd, slot_wr, slot_wdata,
    input  slot_rdata, slot_ack
  );

  modport slave (
    output cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    input  cpu_din, cpu_stall,
    input  slot_cs, slot_addr, slot_rd, slot_wr, slot_wdata,
    output slot_rdata, slot_ack
  );

endinterface

// File: rtl/io_page_decoder.sv
// Combinational page decoder: address page to one-hot slot select, slot hit
// and status-page flag. The status page takes priority over any slot page.
module io_page_decoder #(
  parameter int unsigned N_SLOTS   = 8,
  parameter logic [7:0]  PAGE_BASE = 8'h67,
  parameter logic [7:0]  STAT_PAGE = 8'hFF
) (
  input  logic [7:0]         i_page,
  output logic [N_SLOTS-1:0] o_sel,
  output logic               o_hit,
  output logic               o_stat
);

  logic [7:0] w_off;

  always_comb begin
    w_off  = i_page - PAGE_BASE;
    o_stat = (i_page == STAT_PAGE);
    o_hit  = 1'b0;
    o_sel  = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!o_stat && (w_off == 8'(i))) begin
        o_hit    = 1'b1;
        o_sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_fabric.sv
// I/O interconnect between the J1 CPU port and N peripheral slots: page
// decode, stall while a slot works, timeout/unmapped completion and status page.
module io_bus_fabric
  import io_bus_pkg::*;
#(
  parameter int unsigned N_SLOTS    = 8,
  parameter logic [7:0]  PAGE_BASE  = 8'h67,
  parameter logic [7:0]  STAT_PAGE  = 8'hFF,
  parameter int unsigned TIMEOUT    = 15,
  parameter logic [15:0] DEFAULT_RD = 16'h0666
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  io_bus_fabric_if.master bus,
  output logic            irq_err
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [N_SLOTS-1:0]   r_cs;
  logic [15:0]          r_addr;
  logic [3:0]           r_slot_addr;
  logic [15:0]          r_wdata;
  logic                 r_is_rd;
  logic                 r_rd_stb;
  logic                 r_wr_stb;
  logic [7:0]           r_cnt;
  logic [15:0]          r_din;
  logic [1:0]           r_flags;
  logic [15:0]          r_err_addr;
  logic [15:0]          r_tocnt;

  logic [N_SLOTS-1:0]   w_sel;
  logic                 w_hit;
  logic                 w_stat;
  logic                 w_req;
  logic                 w_idle_req;
  logic                 w_ack;
  logic [15:0]          w_rdata;
  logic [7:0]           w_cnt_inc;
  logic                 w_timeout;
  logic [15:0]          w_stat_rd;
  logic [1:0]           w_flag_set;
  logic [1:0]           w_flag_clr;

  io_page_decoder #(
    .N_SLOTS   (N_SLOTS),
    .PAGE_BASE (PAGE_BASE),
    .STAT_PAGE (STAT_PAGE)
  ) u_dec (
    .i_page (bus.cpu_addr[15:8]),
    .o_sel  (w_sel),
    .o_hit  (w_hit),
    .o_stat (w_stat)
  );

  assign w_req      = bus.cpu_rd | bus.cpu_wr;
  assign w_idle_req = (r_state == ST_IDLE) && w_req;

  // r_cs is only non-zero in WAIT, so stray acks and acks outside WAIT drop out here.
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (r_cs[i]) begin
        w_ack   = bus.slot_ack[i];
        w_rdata = bus.slot_rdata[16*i +: 16];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = r_cnt + 8'd1;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = w_hit ? ST_WAIT : ST_DONE;
      ST_WAIT: begin
        if (w_ack) begin
          w_state_nxt = ST_DONE;
        end else if (w_cnt_inc == TO_LIMIT) begin
          w_state_nxt = ST_DONE;
          w_timeout   = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stat_rd = '0;
    case (bus.cpu_addr[3:0])
      STAT_FLAGS: w_stat_rd = {14'b0, r_flags};
      STAT_ADDR:  w_stat_rd = r_err_addr;
      STAT_TOCNT: w_stat_rd = r_tocnt;
      default:    w_stat_rd = '0;
    endcase
  end

  always_comb begin
    w_flag_set                = '0;
    w_flag_set[FLAG_UNMAPPED] = w_idle_req && !w_hit && !w_stat;
    w_flag_set[FLAG_TIMEOUT]  = w_timeout;
    w_flag_clr                = '0;
    if (w_idle_req && w_stat && !bus.cpu_rd && (bus.cpu_addr[3:0] == STAT_FLAGS))
      w_flag_clr = bus.cpu_dout[1:0];
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state     <= ST_IDLE;
      r_cs        <= '0;
      r_addr      <= '0;
      r_slot_addr <= '0;
      r_wdata     <= '0;
      r_is_rd     <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_cnt       <= '0;
      r_din       <= '0;
      r_flags     <= '0;
      r_err_addr  <= '0;
      r_tocnt     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
      // Set is applied after the clear so a simultaneous set always wins.
      r_flags  <= (r_flags & ~w_flag_clr) | w_flag_set;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              r_cs        <= w_sel;
              r_addr      <= bus.cpu_addr;
              r_slot_addr <= bus.cpu_addr[3:0];
              r_wdata     <= bus.cpu_dout;
              r_is_rd     <= bus.cpu_rd;
              r_rd_stb    <= bus.cpu_rd;
              r_wr_stb    <= !bus.cpu_rd;
              r_cnt       <= '0;
            end else if (w_stat) begin
              if (bus.cpu_rd) r_din <= w_stat_rd;
            end else begin
              if (bus.cpu_rd) r_din <= DEFAULT_RD;
              r_err_addr <= bus.cpu_addr;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_ack) begin
            if (r_is_rd) r_din <= w_rdata;
            r_cs <= '0;
          end else if (w_timeout) begin
            if (r_is_rd) r_din <= DEFAULT_RD;
            r_err_addr <= r_addr;
            if (r_tocnt != '1) r_tocnt <= r_tocnt + 16'd1;
            r_cs <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_din    = r_din;
  assign bus.cpu_stall  = (r_state == ST_WAIT) || (w_idle_req && w_hit);
  assign bus.slot_cs    = r_cs;
  assign bus.slot_addr  = r_slot_addr;
  assign bus.slot_rd    = r_rd_stb;
  assign bus.slot_wr    = r_wr_stb;
  assign bus.slot_wdata = r_wdata;
  assign irq_err        = |r_flags;

endmodule

// File: tb/tb_io_bus_fabric.sv
// Scoreboard bench for io_bus_fabric: a reference model predicts each access's
// completion cycle and read data, the DUT's completion pops and checks it.
module tb_io_bus_fabric;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_err;

  always #5 clk = ~clk;

  io_bus_fabric_if #(.N_SLOTS(8)) bus ();

  io_bus_fabric #(
    .N_SLOTS    (8),
    .PAGE_BASE  (8'h67),
    .STAT_PAGE  (8'hFF),
    .TIMEOUT    (15),
    .DEFAULT_RD (16'h0666)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus),
    .irq_err   (irq_err)
  );

  typedef struct {
    logic [15:0] din;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errs   = 0;

  logic [1:0]  m_flags;
  logic [15:0] m_err_addr;
  logic [15:0] m_tocnt;
  logic [15:0] m_din;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flags    = '0;
    m_err_addr = '0;
    m_tocnt    = '0;
    m_din      = '0;
  endtask

  // ack_cyc outside 1..15 means the slot never answers.
  task automatic access(input bit rd, input logic [15:0] addr, input logic [15:0] wdata,
                        input int ack_cyc, input logic [15:0] rdata, input bit stray);
    exp_t        e;
    exp_t        got;
    int          page;
    int          slot;
    bit          is_slot;
    bit          is_stat;
    int          done_cyc;
    int          stall_cnt;
    int          rd_cnt;
    int          wr_cnt;
    int          cs_bad;
    bit          fin;
    logic [7:0]  exp_cs;
    logic [15:0] sv;

    page    = int'(addr[15:8]);
    slot    = page - 'h67;
    is_stat = (page == 'hFF);
    is_slot = !is_stat && slot >= 0 && slot < 8;

    if (is_slot) begin
      if (ack_cyc >= 1 && ack_cyc <= 15) begin
        done_cyc = ack_cyc + 1;
        if (rd) m_din = rdata;
      end else begin
        done_cyc   = 16;
        if (rd) m_din = 16'h0666;
        m_flags[1] = 1'b1;
        m_err_addr = addr;
        if (m_tocnt != 16'hFFFF) m_tocnt = m_tocnt + 16'd1;
      end
    end else if (is_stat) begin
      done_cyc = 1;
      if (rd) begin
        case (addr[3:0])
          4'd0:    sv = {14'b0, m_flags};
          4'd1:    sv = m_err_addr;
          4'd2:    sv = m_tocnt;
          default: sv = 16'h0000;
        endcase
        m_din = sv;
      end else if (addr[3:0] == 4'd0) begin
        m_flags = m_flags & ~wdata[1:0];
      end
    end else begin
      done_cyc   = 1;
      if (rd) m_din = 16'h0666;
      m_flags[0] = 1'b1;
      m_err_addr = addr;
    end
    e.din = m_din;
    e.cyc = done_cyc;
    sbq.push_back(e);

    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; cs_bad = 0; fin = 1'b0;
    @(negedge clk);
    bus.cpu_addr = addr;
    bus.cpu_rd   = rd;
    bus.cpu_wr   = !rd;
    bus.cpu_dout = wdata;
    if (is_slot) bus.slot_rdata[16*slot +: 16] = rdata;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (k > 0) @(negedge clk);
      bus.slot_ack = '0;
      if (is_slot) begin
        if (k == ack_cyc) bus.slot_ack[slot] = 1'b1;
        else if (stray && k > 0) bus.slot_ack[slot ^ 1] = 1'b1;
      end
      #1;
      if (bus.cpu_stall) stall_cnt++;
      if (bus.slot_rd) rd_cnt++;
      if (bus.slot_wr) wr_cnt++;
      exp_cs = (is_slot && k >= 1 && k < done_cyc) ? 8'(1 << slot) : 8'h00;
      if (bus.slot_cs !== exp_cs) cs_bad++;
      if (is_slot && k == 1) begin
        check_eq("slot_addr", bus.slot_addr, addr[3:0]);
        check_eq("slot_wdata", bus.slot_wdata, wdata);
        check_eq("strobe_c1", {bus.slot_rd, bus.slot_wr}, {rd, !rd});
      end
      if (k >= 1 && !bus.cpu_stall) begin
        fin = 1'b1;
        got = sbq.pop_front();
        check_eq("done_cyc", k, got.cyc);
        check_eq("cpu_din", bus.cpu_din, got.din);
        check_eq("irq_err", irq_err, |m_flags);
      end
    end
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.slot_ack = '0;
    if (!fin) begin
      check_eq("done_bound", 0, 1);
      void'(sbq.pop_front());
    end
    check_eq("stall_cnt", stall_cnt, is_slot ? done_cyc : 0);
    check_eq("rd_pulses", rd_cnt, (is_slot && rd) ? 1 : 0);
    check_eq("wr_pulses", wr_cnt, (is_slot && !rd) ? 1 : 0);
    check_eq("cs_bad", cs_bad, 0);
  endtask

  initial begin
    bus.cpu_addr   = '0;
    bus.cpu_rd     = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_dout   = '0;
    bus.slot_ack   = '0;
    for (int i = 0; i < 8; i++) bus.slot_rdata[16*i +: 16] = 16'hA000 + 16'(i);
    model_reset();

    #23;
    check_eq("rst_din", bus.cpu_din, 16'h0000);
    check_eq("rst_stall", bus.cpu_stall, 1'b0);
    check_eq("rst_cs", bus.slot_cs, 8'h00);
    check_eq("rst_strobes", {bus.slot_rd, bus.slot_wr}, 2'b00);
    check_eq("rst_addr", bus.slot_addr, 4'h0);
    check_eq("rst_wdata", bus.slot_wdata, 16'h0000);
    check_eq("rst_irq", irq_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    access(1, 16'h6903, 16'h0000, 1, 16'hBEEF, 0);   // slot 2, fastest ack
    access(0, 16'h6701, 16'h1234, 4, 16'h5555, 0);   // slot 0 write, din unchanged
    access(1, 16'h1005, 16'h0000, 1, 16'h0000, 0);   // unmapped
    access(1, 16'hFF00, 16'h0000, 0, 16'h0000, 0);
    access(1, 16'hFF01, 16'h0000, 0, 16'h0000, 0);
    access(0, 16'hFF00, 16'h0003, 0, 16'h0000, 0);   // W1C both flags
    access(1, 16'hFF00, 16'h0000, 0, 16'h0000, 0);
    access(1, 16'h6C02, 16'h0000, 0, 16'h1111, 1);   // slot 5 timeout, stray acks
    access(1, 16'hFF02, 16'h0000, 0, 16'h0000, 0);
    access(1, 16'hFF01, 16'h0000, 0, 16'h0000, 0);
    access(0, 16'h6E0F, 16'hCAFE, 0, 16'h2222, 0);   // slot 7 write timeout
    access(1, 16'hFF02, 16'h0000, 0, 16'h0000, 0);
    access(0, 16'hFF00, 16'h0001, 0, 16'h0000, 0);   // clear UNMAPPED only
    access(1, 16'hFF00, 16'h0000, 0, 16'h0000, 0);
    access(0, 16'hFF00, 16'h0003, 0, 16'h0000, 0);
    access(1, 16'h6805, 16'h0000, 15, 16'h7E57, 1);  // ack on the timeout cycle
    access(1, 16'hFF00, 16'h0000, 0, 16'h0000, 0);
    access(1, 16'hFF07, 16'h0000, 0, 16'h0000, 0);
    access(0, 16'h3344, 16'h9999, 0, 16'h0000, 0);   // unmapped write
    access(1, 16'hFF01, 16'h0000, 0, 16'h0000, 0);

    // Reset in the middle of WAIT.
    @(negedge clk);
    bus.cpu_addr = 16'h6A00;
    bus.cpu_rd   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("mid_cs", bus.slot_cs, 8'h08);
    #2;
    rst        = 1'b1;
    bus.cpu_rd = 1'b0;
    #1;
    check_eq("arst_cs", bus.slot_cs, 8'h00);
    check_eq("arst_stall", bus.cpu_stall, 1'b0);
    check_eq("arst_irq", irq_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    access(1, 16'h6B09, 16'h0000, 2, 16'h4321, 0);
    access(1, 16'hFF02, 16'h0000, 0, 16'h0000, 0);

    for (int n = 0; n < 6; n++) begin
      access(1'($urandom_range(0, 1)), {8'(8'h67 + 8'($urandom_range(0, 7))), 8'($urandom_range(0, 15))},
             16'($urandom), int'($urandom_range(1, 18)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    access(1, 16'hFF00, 16'h0000, 0, 16'h0000, 0);
    access(1, 16'hFF02, 16'h0000, 0, 16'h0000, 0);

    check_eq("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/io_bus_fabric.md
# io_bus_fabric

Parametrised I/O interconnect between the J1 CPU port and N peripheral slots; it replaces the fixed page decoder and read mux in the SoC top. It decodes the upper address bits to a one-hot slot select and holds the CPU with a stall while a slot acknowledges. It completes unmapped or unresponsive accesses with a default word, and reports the errors through an internal status page.

## Interface
- N_SLOTS, 8, number of peripheral slots (1..16)
- PAGE_BASE, 8'h67, page of slot 0; slot i answers at page PAGE_BASE+i
- STAT_PAGE, 8'hFF, page of the fabric's own status registers
- TIMEOUT, 15, maximum cycles waited for slot_ack (1..255)
- DEFAULT_RD, 16'h0666, read data for unmapped or timed-out reads
- sys_clk_i  in  1  single clock, rising edge
- sys_rst_i  in  1  reset, asynchronous, active-high
- cpu_addr  in  16  CPU I/O address; [15:8] page, [3:0] register offset
- cpu_rd / cpu_wr  in  1  CPU read / write request; held while cpu_stall=1
- cpu_dout  in  16  CPU write data
- cpu_din  out  16  registered read data to CPU
- cpu_stall  out  1  CPU must hold its request
- slot_cs  out  N_SLOTS  one-hot select
- slot_addr  out  4  registered cpu_addr[3:0]
- slot_rd / slot_wr  out  1  one-cycle strobes
- slot_wdata  out  16  registered cpu_dout
- slot_rdata  in  16*N_SLOTS  flattened; slot i at [16i+15:16i]
- slot_ack  in  N_SLOTS  slot completion, one cycle
- irq_err  out  1  OR of the sticky error bits

## Operation
- FSM: IDLE, WAIT, DONE.
- IDLE, request on a mapped page: go to WAIT, latch slot index/addr/wdata/direction, clear wait counter.
- IDLE, request on an unmapped page: no WAIT; go to DONE, cpu_din<=DEFAULT_RD (reads), set sticky UNMAPPED, err_addr<=cpu_addr.
- IDLE, request on STAT_PAGE: go to DONE in one cycle, no stall.
  - Reads: offset 0 returns {14'b0, TIMEOUT_ERR, UNMAPPED}; offset 1 returns err_addr; offset 2 returns timeout_count; other offsets return 0.
  - Write to offset 0: write-1-to-clear of the sticky bits. Other writes are ignored.
- WAIT: slot_cs[i]=1 throughout. slot_rd/slot_wr are high only in the first WAIT cycle.
  - slot_ack[i]=1: cpu_din<=slot_rdata[i] (reads only), go to DONE.
  - Otherwise the counter increments. On the cycle the counter reaches TIMEOUT with no ack: go to DONE, cpu_din<=DEFAULT_RD, set TIMEOUT_ERR, err_addr<=latched address, timeout_count+=1 (saturating at 16'hFFFF).
- DONE: slot_cs=0, stall low; the CPU request is ignored; go to IDLE next cycle.
- cpu_din holds its value until the next completed read; writes never change it.
- Acks from non-selected slots and acks outside WAIT are ignored.
- cpu_stall = (state==WAIT) | (state==IDLE & request & page is a slot page).

## Timing
- Reset values:
  - state=IDLE
  - cpu_din=16'h0000, slot_cs=0, slot_rd=slot_wr=0, slot_addr=0, slot_wdata=0
  - sticky bits, err_addr, timeout_count = 0
  - irq_err=0, cpu_stall=0
- Mapped access: request in cycle 0 (stall=1); WAIT from cycle 1 with strobe in cycle 1; ack sampled from cycle 1 on.
  - Ack in cycle n gives data valid and stall=0 in cycle n+1 (DONE). Minimum is 2 cycles, with ack in cycle 1.
- Timeout: with no ack in cycles 1..TIMEOUT, DONE is in cycle TIMEOUT+1.
- An ack in the same cycle the counter reaches TIMEOUT wins: normal completion, no error.
- Status and unmapped accesses: DONE in cycle 1.
- When a sticky-bit set and a W1C clear happen in the same cycle, set wins.
- Reset mid-access: asynchronous return to reset values; the slot transaction is abandoned, and no ack is expected afterwards.

## Structure
- Package io_bus_pkg: FSM state enum, status offset constants (STAT_FLAGS=0, STAT_ADDR=1, STAT_TOCNT=2), flag bit positions.
- Sub-module io_page_decoder (combinational): page → one-hot slot select, hit, status-page flag. Reused by later SoC revisions.
- The fabric holds the FSM, the counter, the status registers and the registered read mux.

## Test plan
- Read of slot 2 (page 8'h69, offset 3), slot acks in cycle 1 with 16'hBEEF → slot_cs=8'b00000100, slot_rd pulse in cycle 1, cpu_din=16'hBEEF and stall=0 in cycle 2.
- Write 16'h1234 to slot 0 with ack after 4 cycles → slot_wdata=16'h1234, one slot_wr pulse, stall high for 5 cycles, cpu_din unchanged.
- Read of page 8'h10 → cpu_din=16'h0666 in cycle 1, no slot_cs, UNMAPPED=1, err_addr=16'h10xx, irq_err=1.
- Slot never acks (TIMEOUT=15) → DONE in cycle 16, cpu_din=16'h0666, timeout_count=1; a second time gives 2. Ack exactly in cycle 15 → normal data, no error.
- Write 16'h0003 to 8'hFF00 → flags cleared, irq_err=0. Clear in the same cycle as a new timeout → TIMEOUT_ERR stays 1.
- Assert sys_rst_i in the middle of WAIT → slot_cs=0 and cpu_stall=0 immediately; the next access behaves normally.
